// File: rtl/bmp_frame_packer.sv
// Packs multi-pixel RGB/grey beats into BMP frame-store writes: BGR byte order,
// bottom-up or top-down row order, 4-byte row padding, completion and overrun flags.
module bmp_frame_packer #(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512,
    parameter int PIX_PER_CLK  = 2,
    parameter int CHANNELS     = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int BOTTOM_UP    = 1,
    parameter int ADDR_WIDTH   = 21
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        frame_Start,
    input  logic                                        horizontal_Pulse,
    input  logic [PIX_PER_CLK*CHANNELS*DATA_WIDTH-1:0]  pix_Data,
    output logic                                        mem_We,
    output logic [ADDR_WIDTH-1:0]                       mem_Addr,
    output logic [PIX_PER_CLK*CHANNELS*DATA_WIDTH-1:0]  mem_Wdata,
    output logic                                        sig_Write_Done,
    output logic                                        sig_Overrun
);

    localparam int BEAT_W    = PIX_PER_CLK * CHANNELS * DATA_WIDTH;
    localparam int ROW_BYTES = ((IMAGE_WIDTH * CHANNELS + 3) / 4) * 4;
    localparam int M_W       = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int L_W       = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [M_W-1:0]        M_LAST      = M_W'(IMAGE_WIDTH - PIX_PER_CLK);
    localparam logic [M_W-1:0]        M_STEP      = M_W'(PIX_PER_CLK);
    localparam logic [L_W-1:0]        L_LAST      = L_W'(IMAGE_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] A_ROW_BYTES = ADDR_WIDTH'(ROW_BYTES);
    localparam logic [ADDR_WIDTH-1:0] A_CHANNELS  = ADDR_WIDTH'(CHANNELS);
    localparam logic [ADDR_WIDTH-1:0] A_LAST_ROW  = ADDR_WIDTH'(IMAGE_HEIGHT - 1);

    // Reject parameter sets the address and counter arithmetic cannot represent.
    if (!(PIX_PER_CLK == 1 || PIX_PER_CLK == 2 || PIX_PER_CLK == 4)) begin : g_bad_pix
        $fatal(1, "bmp_frame_packer: PIX_PER_CLK must be 1, 2 or 4");
    end
    if (!(CHANNELS == 1 || CHANNELS == 3)) begin : g_bad_ch
        $fatal(1, "bmp_frame_packer: CHANNELS must be 1 or 3");
    end
    if (IMAGE_WIDTH < PIX_PER_CLK || (IMAGE_WIDTH % PIX_PER_CLK) != 0) begin : g_bad_width
        $fatal(1, "bmp_frame_packer: IMAGE_WIDTH must be a multiple of PIX_PER_CLK");
    end
    if (IMAGE_HEIGHT < 1 || DATA_WIDTH < 1) begin : g_bad_size
        $fatal(1, "bmp_frame_packer: IMAGE_HEIGHT and DATA_WIDTH must be positive");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 62 ||
        longint'(IMAGE_HEIGHT) * longint'(ROW_BYTES) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_addr
        $fatal(1, "bmp_frame_packer: ADDR_WIDTH too small for IMAGE_HEIGHT*ROW_BYTES");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [M_W-1:0]          r_m;
    logic [L_W-1:0]          r_l;
    logic                    w_accept;
    logic                    w_overrun;
    logic                    w_row_end;
    logic                    w_last;
    logic [ADDR_WIDTH-1:0]   w_row_index;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [BEAT_W-1:0]       w_wdata;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // if/else tree can leave it unassigned and infer a latch.
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_overrun   = 1'b0;
        w_row_end   = (r_m == M_LAST);
        w_last      = w_row_end && (r_l == L_LAST);

        if (frame_Start) begin
            // A beat coinciding with frame_Start is dropped silently.
            w_state_nxt = S_ACTIVE;
        end else if (horizontal_Pulse) begin
            if (r_state == S_ACTIVE) begin
                w_accept = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end else begin
                w_overrun = 1'b1;
            end
        end
    end

    always_comb begin
        w_row_index = (BOTTOM_UP != 0) ? (A_LAST_ROW - ADDR_WIDTH'(r_l)) : ADDR_WIDTH'(r_l);
        w_addr      = w_row_index * A_ROW_BYTES + ADDR_WIDTH'(r_m) * A_CHANNELS;
    end

    // RGB -> BGR within each pixel; with one channel this is the identity.
    always_comb begin
        w_wdata = '0;
        for (int p = 0; p < PIX_PER_CLK; p++) begin
            for (int j = 0; j < CHANNELS; j++) begin
                w_wdata[(p*CHANNELS + j)*DATA_WIDTH +: DATA_WIDTH] =
                    pix_Data[(p*CHANNELS + CHANNELS - 1 - j)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m <= '0;
            r_l <= '0;
        end else if (frame_Start) begin
            r_m <= '0;
            r_l <= '0;
        end else if (w_accept) begin
            if (w_row_end) begin
                r_m <= '0;
                r_l <= w_last ? '0 : r_l + 1'b1;
            end else begin
                r_m <= r_m + M_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_We         <= 1'b0;
            mem_Addr       <= '0;
            mem_Wdata      <= '0;
            sig_Write_Done <= 1'b0;
            sig_Overrun    <= 1'b0;
        end else begin
            mem_We      <= w_accept;
            sig_Overrun <= w_overrun;
            if (w_accept) begin
                mem_Addr  <= w_addr;
                mem_Wdata <= w_wdata;
            end
            if (frame_Start) begin
                sig_Write_Done <= 1'b0;
            end else if (w_accept && w_last) begin
                sig_Write_Done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bmp_frame_packer.sv
// Bench for bmp_frame_packer: table-driven grey top-down frame, directed corner
// sequences and randomized RGB traffic compared against a beat-count reference model.
module tb_bmp_frame_packer;

    localparam int A_W     = 6;
    localparam int A_H     = 2;
    localparam int A_P     = 2;
    localparam int A_C     = 3;
    localparam int A_BU    = 1;
    localparam int A_AW    = 8;
    localparam int A_BW    = A_P * A_C * 8;
    localparam int A_RB    = ((A_W * A_C + 3) / 4) * 4;
    localparam int A_BEATS = (A_W * A_H) / A_P;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              a_fs = 1'b0, a_hp = 1'b0;
    logic [A_BW-1:0]   a_pix = '0;
    logic              a_we, a_done, a_ov;
    logic [A_AW-1:0]   a_addr;
    logic [A_BW-1:0]   a_wdata;

    logic              b_fs = 1'b0, b_hp = 1'b0;
    logic [7:0]        b_pix = '0;
    logic              b_we, b_done, b_ov;
    logic [7:0]        b_addr;
    logic [7:0]        b_wdata;

    bmp_frame_packer #(
        .IMAGE_WIDTH(A_W), .IMAGE_HEIGHT(A_H), .PIX_PER_CLK(A_P), .CHANNELS(A_C),
        .DATA_WIDTH(8), .BOTTOM_UP(A_BU), .ADDR_WIDTH(A_AW)
    ) u_a (
        .clk(clk), .reset(reset), .frame_Start(a_fs), .horizontal_Pulse(a_hp),
        .pix_Data(a_pix), .mem_We(a_we), .mem_Addr(a_addr), .mem_Wdata(a_wdata),
        .sig_Write_Done(a_done), .sig_Overrun(a_ov)
    );

    bmp_frame_packer #(
        .IMAGE_WIDTH(5), .IMAGE_HEIGHT(2), .PIX_PER_CLK(1), .CHANNELS(1),
        .DATA_WIDTH(8), .BOTTOM_UP(0), .ADDR_WIDTH(8)
    ) u_b (
        .clk(clk), .reset(reset), .frame_Start(b_fs), .horizontal_Pulse(b_hp),
        .pix_Data(b_pix), .mem_We(b_we), .mem_Addr(b_addr), .mem_Wdata(b_wdata),
        .sig_Write_Done(b_done), .sig_Overrun(b_ov)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks mode and the number of beats accepted in the frame.
    int              m_mode;   // 0 idle, 1 capturing, 2 complete
    int              m_k;
    logic            e_we, e_ov, e_done;
    logic [A_AW-1:0] e_addr;
    logic [A_BW-1:0] e_wdata;

    function automatic logic [A_AW-1:0] a_addr_of(input int k);
        int pix, l, m, row;
        pix = k * A_P;
        l   = pix / A_W;
        m   = pix % A_W;
        row = (A_BU != 0) ? (A_H - 1 - l) : l;
        return A_AW'(row * A_RB + m * A_C);
    endfunction

    function automatic logic [A_BW-1:0] a_swap(input logic [A_BW-1:0] d);
        logic [A_BW-1:0] o;
        o = '0;
        for (int p = 0; p < A_P; p++)
            o[p*24 +: 24] = {d[p*24 +: 8], d[p*24+8 +: 8], d[p*24+16 +: 8]};
        return o;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_k = 0;
        e_we = 0; e_ov = 0; e_done = 0; e_addr = '0; e_wdata = '0;
    endtask

    task automatic model_step(input logic fs, input logic hp, input logic [A_BW-1:0] d);
        e_we = 0;
        e_ov = 0;
        if (fs) begin
            m_mode = 1; m_k = 0; e_done = 0;
        end else if (hp) begin
            if (m_mode == 1) begin
                e_we    = 1;
                e_addr  = a_addr_of(m_k);
                e_wdata = a_swap(d);
                m_k++;
                if (m_k == A_BEATS) begin
                    m_mode = 2; e_done = 1;
                end
            end else begin
                e_ov = 1;
            end
        end
    endtask

    task automatic check_a(input string tag);
        check({tag, "_we"},    64'(a_we),    64'(e_we));
        check({tag, "_addr"},  64'(a_addr),  64'(e_addr));
        check({tag, "_wdata"}, 64'(a_wdata), 64'(e_wdata));
        check({tag, "_done"},  64'(a_done),  64'(e_done));
        check({tag, "_ov"},    64'(a_ov),    64'(e_ov));
    endtask

    task automatic step_a(input logic fs, input logic hp, input logic [A_BW-1:0] d, input string tag);
        a_fs = fs; a_hp = hp; a_pix = d;
        @(posedge clk);
        model_step(fs, hp, d);
        #1;
        check_a(tag);
    endtask

    function automatic logic [A_BW-1:0] rnd_beat();
        return A_BW'({$urandom(), $urandom()});
    endfunction

    typedef struct {
        logic       fs;
        logic       hp;
        logic [7:0] data;
        logic       exp_we;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        logic       exp_done;
    } vec_t;

    vec_t        tbl [12];
    logic [7:0]  b_seq [10];
    logic [7:0]  t1_seq [6];

    initial begin
        b_seq  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
        t1_seq = '{8'd20, 8'd26, 8'd32, 8'd0, 8'd6, 8'd12};
        tbl[0] = '{fs: 1'b1, hp: 1'b0, data: 8'h00, exp_we: 1'b0, exp_addr: 8'd0,
                   exp_data: 8'h00, exp_done: 1'b0};
        for (int i = 1; i <= 10; i++)
            tbl[i] = '{fs: 1'b0, hp: 1'b1, data: 8'(8'h40 + i), exp_we: 1'b1,
                       exp_addr: b_seq[i-1], exp_data: 8'(8'h40 + i), exp_done: (i == 10)};
        tbl[11] = '{fs: 1'b0, hp: 1'b0, data: 8'h99, exp_we: 1'b0, exp_addr: 8'd12,
                    exp_data: 8'h4a, exp_done: 1'b1};

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_a("rst");
        check("rst_b_we",   64'(b_we),    64'd0);
        check("rst_b_addr", 64'(b_addr),  64'd0);
        check("rst_b_done", 64'(b_done),  64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Top-down grey frame on the second instance
        for (int i = 0; i < 12; i++) begin
            b_fs = tbl[i].fs; b_hp = tbl[i].hp; b_pix = tbl[i].data;
            @(posedge clk); #1;
            check($sformatf("t3_we_%0d", i),   64'(b_we),    64'(tbl[i].exp_we));
            check($sformatf("t3_addr_%0d", i), 64'(b_addr),  64'(tbl[i].exp_addr));
            check($sformatf("t3_data_%0d", i), 64'(b_wdata), 64'(tbl[i].exp_data));
            check($sformatf("t3_done_%0d", i), 64'(b_done),  64'(tbl[i].exp_done));
            check($sformatf("t3_ov_%0d", i),   64'(b_ov),    64'd0);
        end
        b_fs = 0; b_hp = 0;

        // Overrun while idle
        step_a(0, 1, rnd_beat(), "t4_idle_ov");
        step_a(0, 0, '0, "t4_idle_quiet");

        // Address sequence, padding and byte reorder
        step_a(1, 0, '0, "t1_start");
        for (int i = 0; i < 6; i++) begin
            step_a(0, 1, (i == 0) ? 48'h665544_332211 : rnd_beat(), "t1");
            check($sformatf("t1_addr_%0d", i), 64'(a_addr), 64'(t1_seq[i]));
            check($sformatf("t1_done_%0d", i), 64'(a_done), 64'(i == 5));
            if (i == 0) check("t2_wdata", 64'(a_wdata), 64'h4455_6611_2233);
        end

        // Overrun after completion, then restart
        step_a(0, 0, '0, "t4_gap");
        step_a(0, 1, rnd_beat(), "t4_done_ov");
        check("t4_ov_pulse", 64'(a_ov), 64'd1);
        step_a(0, 0, '0, "t4_after_ov");
        step_a(1, 0, '0, "t4_restart");
        check("t4_done_clr", 64'(a_done), 64'd0);
        step_a(0, 1, rnd_beat(), "t4_first");
        check("t4_addr20", 64'(a_addr), 64'd20);

        // Start and beat together, then gapped beats
        step_a(1, 1, rnd_beat(), "t5_start_beat");
        check("t5_no_ov", 64'(a_ov), 64'd0);
        step_a(0, 1, rnd_beat(), "t5_first");
        check("t5_addr20", 64'(a_addr), 64'd20);
        for (int i = 0; i < 3; i++) step_a(0, 0, rnd_beat(), "t5_gap");
        step_a(0, 1, rnd_beat(), "t5_second");
        check("t5_addr26", 64'(a_addr), 64'd26);

        // Reset in the middle of a frame
        step_a(1, 0, '0, "t6_start");
        for (int i = 0; i < 3; i++) step_a(0, 1, rnd_beat(), "t6_beat");
        a_hp = 1; a_pix = rnd_beat();
        reset = 1'b0;
        #1;
        model_reset();
        check_a("t6_async");
        @(posedge clk); #1;
        check_a("t6_held");
        reset = 1'b1;
        step_a(0, 1, rnd_beat(), "t6_post_beat");
        step_a(0, 0, '0, "t6_post_idle");
        step_a(1, 0, '0, "t6_restart");
        for (int i = 0; i < A_BEATS; i++) step_a(0, 1, rnd_beat(), "t6_frame");
        check("t6_done", 64'(a_done), 64'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++)
            step_a($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, rnd_beat(), "rnd");

        a_fs = 0; a_hp = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
